// File: rtl/grayscale_convert.sv
// grayscale_convert: RGB byte stream to 8-bit grayscale pixel stream.
//
// Bytes arrive R, G, B per pixel on a one-cycle strobe. Each completed
// triple goes through a two-stage pipeline: a weighted sum is registered,
// then its top byte becomes the output pixel with a one-cycle ready pulse.
// A pixel is presented two edges after its B byte is sampled.
//
// Optional build macro: GRAY_FAST_APPROX_EN
//   undefined (default) : gray = (R*R_COEF + G*G_COEF + B*B_COEF + 128) >> 8
//   defined             : gray = (R + 2*G + B + 2) >> 2, multiplier-free;
//                         the coefficient parameters are then ignored.
//
// Handshake: a byte is taken on a rising edge only when start_gray_i and
// in_byte_rdy_i are both high; there is no backpressure. px_rdy_o is high
// for exactly one cycle per pixel and out_px_gray_o holds between pulses.

module grayscale_convert #(
    parameter int unsigned R_COEF = 77,   // red weight
    parameter int unsigned G_COEF = 150,  // green weight
    parameter int unsigned B_COEF = 29    // blue weight, R+G+B weights sum to 256
) (
    input  logic        clk_i,
    input  logic        nreset_i,
    input  logic        start_gray_i,
    input  logic        in_byte_rdy_i,
    input  logic [7:0]  in_byte_i,
    output logic [7:0]  out_px_gray_o,
    output logic        px_rdy_o,
    output logic [23:0] frame_px_cnt_o
);

    // Byte phase within the current pixel; this is the block's only FSM.
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    phase_e      phase_q;
    logic [7:0]  r_q;
    logic [7:0]  g_q;
    logic [7:0]  b_q;
    logic        s1_valid_q;   // triple in r_q/g_q/b_q is complete, one cycle
    logic [15:0] sum_d;
    logic [15:0] sum_q;
    logic        s2_valid_q;   // sum_q holds a new pixel, one cycle
    logic [7:0]  gray_d;
    logic [7:0]  out_px_q;
    logic        px_rdy_q;
    logic [23:0] cnt_d;
    logic [23:0] cnt_q;
    logic        byte_take;

    assign byte_take = start_gray_i & in_byte_rdy_i;

    // Byte capture FSM: route each accepted byte by phase, realign on idle.
    // The B byte raises s1_valid_q for a single cycle; the next R byte may
    // land on the same edge that stage 1 consumes the triple, which is safe
    // because stage 1 samples the pre-edge register values.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            phase_q    <= PH_R;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= 1'b0;
            if (!start_gray_i) begin
                // Partial R/G bytes are abandoned simply by restarting at R.
                phase_q <= PH_R;
            end else if (byte_take) begin
                case (phase_q)
                    PH_R: begin
                        r_q     <= in_byte_i;
                        phase_q <= PH_G;
                    end
                    PH_G: begin
                        g_q     <= in_byte_i;
                        phase_q <= PH_B;
                    end
                    PH_B: begin
                        b_q        <= in_byte_i;
                        s1_valid_q <= 1'b1;
                        phase_q    <= PH_R;
                    end
                    default: begin
                        phase_q <= PH_R;
                    end
                endcase
            end
        end
    end

`ifdef GRAY_FAST_APPROX_EN
    // Coefficients are not used in this build; keep them referenced.
    localparam int unsigned COEF_SUM_UNUSED = R_COEF + G_COEF + B_COEF;

    // Stage 1 arithmetic, approximation: R + 2G + B + 2 (fits in 10 bits).
    always_comb begin
        sum_d = {8'd0, r_q} + {7'd0, g_q, 1'b0} + {8'd0, b_q} + 16'd2;
    end

    // Stage 2 selection: divide by four.
    always_comb begin
        gray_d = sum_q[9:2];
    end

    logic sum_bits_unused;
    assign sum_bits_unused = ^{sum_q[15:10], sum_q[1:0]};
`else
    localparam logic [15:0] R_W = 16'(R_COEF);
    localparam logic [15:0] G_W = 16'(G_COEF);
    localparam logic [15:0] B_W = 16'(B_COEF);

    // Stage 1 arithmetic: weighted sum with rounding; max 255*256+128 < 2^16.
    always_comb begin
        sum_d = ({8'd0, r_q} * R_W)
              + ({8'd0, g_q} * G_W)
              + ({8'd0, b_q} * B_W)
              + 16'd128;
    end

    // Stage 2 selection: divide by 256; weights summing to 256 keep it <= 255.
    always_comb begin
        gray_d = sum_q[15:8];
    end

    logic sum_bits_unused;
    assign sum_bits_unused = ^sum_q[7:0];
`endif

    // Stage 1 register: capture the sum when a full triple is present.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sum_q      <= 16'd0;
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q <= sum_d;
            end
        end
    end

    // Stage 2 register: publish the pixel, hold it between pulses.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            out_px_q <= 8'd0;
            px_rdy_q <= 1'b0;
        end else begin
            px_rdy_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_px_q <= gray_d;
            end
        end
    end

    // Frame counter next state: a pulse on this edge always counts, even
    // while idle, so an idle cycle that emits a pixel leaves the count at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (!start_gray_i) begin
            cnt_d = s2_valid_q ? 24'd1 : 24'd0;
        end else if (s2_valid_q) begin
            cnt_d = cnt_q + 24'd1;   // wraps 0xFFFFFF -> 0 naturally
        end
    end

    // Frame counter register, updated on the same edge as px_rdy_o.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_px_gray_o  = out_px_q;
    assign px_rdy_o       = px_rdy_q;
    assign frame_px_cnt_o = cnt_q;

endmodule

// File: tb/tb_grayscale_convert.sv
// Testbench for grayscale_convert: driver tasks feed bytes and record the
// expected pixel (value and edge of appearance) in a queue when a triple is
// completed; an independent monitor pops and compares on every px_rdy_o.
module tb_grayscale_convert;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic        start_gray_i;
  logic        in_byte_rdy_i;
  logic [7:0]  in_byte_i;
  logic [7:0]  out_px_gray_o;
  logic        px_rdy_o;
  logic [23:0] frame_px_cnt_o;

  always #5 clk_i = ~clk_i;

  grayscale_convert dut (
    .clk_i          (clk_i),
    .nreset_i       (nreset_i),
    .start_gray_i   (start_gray_i),
    .in_byte_rdy_i  (in_byte_rdy_i),
    .in_byte_i      (in_byte_i),
    .out_px_gray_o  (out_px_gray_o),
    .px_rdy_o       (px_rdy_o),
    .frame_px_cnt_o (frame_px_cnt_o)
  );

  // ---------------- reference model ----------------
  function automatic int gray_ref(input int r, input int g, input int b);
`ifdef GRAY_FAST_APPROX_EN
    return (r + 2 * g + b + 2) / 4;
`else
    return (r * 77 + g * 150 + b * 29 + 128) / 256;
`endif
  endfunction

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         exp_edge_q[$];
  int         part_q[$];
  int         edge_cnt = 0;
  int         cnt_m = 0;
  logic [7:0] last_out = 8'd0;
  logic       mon_start;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    in_byte_i     = b;
    in_byte_rdy_i = 1'b1;
    if (start_gray_i && nreset_i) begin
      part_q.push_back(int'(b));
      if (part_q.size() == 3) begin
        exp_q.push_back(8'(gray_ref(part_q[0], part_q[1], part_q[2])));
        exp_edge_q.push_back(edge_cnt + 3);
        part_q.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      in_byte_rdy_i = 1'b0;
      in_byte_i     = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic set_start(input logic v);
    @(negedge clk_i);
    in_byte_rdy_i = 1'b0;
    start_gray_i  = v;
    if (!v) part_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    nreset_i      = 1'b0;
    in_byte_rdy_i = 1'b0;
    exp_q.delete();
    exp_edge_q.delete();
    part_q.delete();
    @(negedge clk_i);
    nreset_i = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
      exp_edge_q.delete();
    end
    idle(2);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk_i) begin
    edge_cnt++;
    mon_start = start_gray_i;
    #1;
    if (!nreset_i) begin
      cnt_m    = 0;
      last_out = 8'd0;
      check("reset_out", int'(out_px_gray_o), 0);
      check("reset_rdy", int'(px_rdy_o), 0);
      check("reset_cnt", int'(frame_px_cnt_o), 0);
    end else begin
      if (px_rdy_o) begin
        cnt_m = mon_start ? ((cnt_m + 1) & 32'hFFFFFF) : 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual=1 required=0 out=%0d (t=%0t)", out_px_gray_o, $time);
        end else begin
          check("pixel_value", int'(out_px_gray_o), int'(exp_q.pop_front()));
          check("pixel_latency", edge_cnt, exp_edge_q.pop_front());
        end
        last_out = out_px_gray_o;
      end else begin
        if (!mon_start) cnt_m = 0;
        check("out_hold", int'(out_px_gray_o), int'(last_out));
      end
      check("frame_cnt", int'(frame_px_cnt_o), cnt_m);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    nreset_i      = 1'b0;
    start_gray_i  = 1'b0;
    in_byte_rdy_i = 1'b0;
    in_byte_i     = 8'd0;
    repeat (2) @(negedge clk_i);
    check("rst_out_direct", int'(out_px_gray_o), 0);
    check("rst_cnt_direct", int'(frame_px_cnt_o), 0);
    nreset_i = 1'b1;

    // White pixel, back-to-back bytes.
    set_start(1'b1);
    send_byte(8'd255); send_byte(8'd255); send_byte(8'd255);
    drain();
    check("white_value", int'(out_px_gray_o), 255);
    check("white_cnt", int'(frame_px_cnt_o), 1);

    // Mixed pixel 100,50,200.
    set_start(1'b0); set_start(1'b1);
    send_byte(8'd100); send_byte(8'd50); send_byte(8'd200);
    drain();
`ifdef GRAY_FAST_APPROX_EN
    check("mix_value", int'(out_px_gray_o), 100);
`else
    check("mix_value", int'(out_px_gray_o), 82);
`endif

    // Partial pixel abandoned by an idle cycle, then 10,20,30.
    set_start(1'b0); set_start(1'b1);
    send_byte(8'd255); send_byte(8'd255);
    set_start(1'b0); set_start(1'b1);
    send_byte(8'd10); send_byte(8'd20); send_byte(8'd30);
    drain();
`ifdef GRAY_FAST_APPROX_EN
    check("realign_value", int'(out_px_gray_o), 20);
`else
    check("realign_value", int'(out_px_gray_o), 18);
`endif
    check("realign_cnt", int'(frame_px_cnt_o), 1);

    // Reset right after the B byte: pixel must be dropped.
    set_start(1'b0); set_start(1'b1);
    send_byte(8'd90); send_byte(8'd91); send_byte(8'd92);
    do_reset();
    idle(5);
    check("midreset_out", int'(out_px_gray_o), 0);
    check("midreset_cnt", int'(frame_px_cnt_o), 0);

    // Nine pixels with random 0-3 cycle gaps between bytes.
    set_start(1'b0); set_start(1'b1);
    for (int p = 0; p < 9; p++) begin
      for (int k = 0; k < 3; k++) begin
        send_byte(8'($urandom_range(0, 255)));
        idle($urandom_range(0, 3));
      end
    end
    drain();
    check("stream9_cnt", int'(frame_px_cnt_o), 9);

    // Pixel in flight completes after start drops; counter loads 1.
    send_byte(8'd40); send_byte(8'd80); send_byte(8'd120);
    set_start(1'b0);
    drain();
    check("flight_cnt", int'(frame_px_cnt_o), 0);

    // Random mix of bytes, gaps, start toggles and resets.
    set_start(1'b1);
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 75)      send_byte(8'($urandom_range(0, 255)));
      else if (op < 88) idle($urandom_range(1, 3));
      else if (op < 97) set_start(~start_gray_i);
      else              do_reset();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
